// File: rtl/dac_driver_resync.sv
// DAC switch driver: retimes binary/thermometer controls through an LAT-deep pipeline
// and gates them with a supply-aware power sequencer (OFF/WAKE/ACTIVE/FAULT) plus error monitors.
module dac_driver_resync #(
    parameter int  NBIN      = 7,
    parameter int  NTHERM    = 17,
    parameter int  LAT       = 2,
    parameter int  WAKE_CYC  = 8,
    parameter real VDD18_REF = 1.8,
    parameter real VDD08_REF = 0.8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              pdb,
    input  real               vddana_1p8,
    input  real               vddana_0p8,
    input  real               vssana,
    input  logic [NBIN-1:0]   datain,
    input  logic [NBIN-1:0]   datainb,
    input  logic [NTHERM-1:0] datatherm,
    input  logic [NTHERM-1:0] datathermb,
    output wire  [NBIN-1:0]   databinout,
    output wire  [NBIN-1:0]   databinoutb,
    output wire  [NTHERM-1:0] datathermout,
    output wire  [NTHERM-1:0] datathermoutb,
    output logic              ready,
    output logic              compl_err,
    output logic              therm_err,
    output logic [7:0]        err_cnt,
    output logic [1:0]        dbg_state
);

    localparam real V18_LO = VDD18_REF * 0.95;
    localparam real V18_HI = VDD18_REF * 1.05;
    localparam real V08_LO = VDD08_REF * 0.95;
    localparam real V08_HI = VDD08_REF * 1.05;
    localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYC - 1);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_WAKE   = 2'd1,
        S_ACTIVE = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t state, next_state;
    logic [7:0] wake_cnt;
    logic supply_ok, supply_q;
    logic compl_bad, therm_bad;
    logic drive;
    logic [NBIN-1:0]   bin_drv, binb_drv;
    logic [NTHERM-1:0] th_drv, thb_drv;

    logic [NBIN-1:0]   bin_p  [LAT];
    logic [NBIN-1:0]   binb_p [LAT];
    logic [NTHERM-1:0] th_p   [LAT];
    logic [NTHERM-1:0] thb_p  [LAT];

    assign supply_ok = (vddana_1p8 >= V18_LO) && (vddana_1p8 <= V18_HI) &&
                       (vddana_0p8 >= V08_LO) && (vddana_0p8 <= V08_HI) &&
                       (vssana >= -0.05) && (vssana <= 0.05);

    // Retiming pipeline runs in every state so ACTIVE starts with a flushed pipe.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < LAT; i++) begin
                bin_p[i]  <= '0;
                binb_p[i] <= '0;
                th_p[i]   <= '0;
                thb_p[i]  <= '0;
            end
        end else begin
            bin_p[0]  <= datain;
            binb_p[0] <= datainb;
            th_p[0]   <= datatherm;
            thb_p[0]  <= datathermb;
            for (int i = 1; i < LAT; i++) begin
                bin_p[i]  <= bin_p[i-1];
                binb_p[i] <= binb_p[i-1];
                th_p[i]   <= th_p[i-1];
                thb_p[i]  <= thb_p[i-1];
            end
        end
    end

    always_comb begin
        next_state = state;
        if (state == S_OFF) begin
            if (pdb && supply_q) next_state = S_WAKE;
        end else if (!pdb) begin
            next_state = S_OFF;
        end else if (!supply_q) begin
            next_state = S_FAULT;
        end else begin
            case (state)
                S_WAKE:  if (wake_cnt == WAKE_LAST) next_state = S_ACTIVE;
                S_FAULT: next_state = S_WAKE;
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= S_OFF;
            supply_q <= 1'b0;
            wake_cnt <= 8'd0;
        end else begin
            state    <= next_state;
            supply_q <= supply_ok;
            // Counter restarts at zero on every entry into WAKE.
            wake_cnt <= (state == S_WAKE && next_state == S_WAKE) ? wake_cnt + 8'd1 : 8'd0;
        end
    end

    // Stage-1 word checks: complement pairs and contiguous-from-LSB thermometer code.
    assign compl_bad = (bin_p[0] != ~binb_p[0]) || (th_p[0] != ~thb_p[0]);
    assign therm_bad = (th_p[0] & (th_p[0] + NTHERM'(1))) != '0;
    assign compl_err = (state == S_ACTIVE) && compl_bad;
    assign therm_err = (state == S_ACTIVE) && therm_bad;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_cnt <= 8'd0;
        end else if ((compl_err || therm_err) && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    always_comb begin
        drive    = (state != S_OFF);
        bin_drv  = '0;
        binb_drv = '1;
        th_drv   = '0;
        thb_drv  = '1;
        if (state == S_ACTIVE) begin
            bin_drv  = bin_p[LAT-1];
            binb_drv = binb_p[LAT-1];
            th_drv   = th_p[LAT-1];
            thb_drv  = thb_p[LAT-1];
        end
    end

    assign databinout    = drive ? bin_drv  : 'z;
    assign databinoutb   = drive ? binb_drv : 'z;
    assign datathermout  = drive ? th_drv   : 'z;
    assign datathermoutb = drive ? thb_drv  : 'z;
    assign ready         = (state == S_ACTIVE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_dac_driver_resync.sv
// Bench for dac_driver_resync: directed scenarios plus randomized traffic against a
// queue-based behavioural model of power sequencing, latency and error counting.
module tb_dac_driver_resync;

    localparam int NBIN     = 7;
    localparam int NTHERM   = 17;
    localparam int LAT      = 2;
    localparam int WAKE_CYC = 8;

    typedef struct packed {
        logic [NBIN-1:0]   b;
        logic [NBIN-1:0]   bb;
        logic [NTHERM-1:0] t;
        logic [NTHERM-1:0] tb;
    } word_t;

    typedef enum {M_OFF, M_WAKE, M_ACTIVE, M_FAULT} mode_t;

    logic clk = 1'b0;
    logic rstb, pdb;
    real  v18, v08, vss;
    logic [NBIN-1:0]   datain, datainb;
    logic [NTHERM-1:0] datatherm, datathermb;
    wire  [NBIN-1:0]   databinout, databinoutb;
    wire  [NTHERM-1:0] datathermout, datathermoutb;
    logic ready, compl_err, therm_err;
    logic [7:0] err_cnt;
    logic [1:0] dbg_state;
    word_t obs;

    int n_vec = 0;
    int n_err = 0;

    mode_t m_mode;
    int    wake_left;
    bit    m_sup;
    bit    sup_now;
    int    m_cnt;
    word_t hist[$];

    dac_driver_resync #(.NBIN(NBIN), .NTHERM(NTHERM), .LAT(LAT), .WAKE_CYC(WAKE_CYC)) dut (
        .clk(clk), .rstb(rstb), .pdb(pdb),
        .vddana_1p8(v18), .vddana_0p8(v08), .vssana(vss),
        .datain(datain), .datainb(datainb), .datatherm(datatherm), .datathermb(datathermb),
        .databinout(databinout), .databinoutb(databinoutb),
        .datathermout(datathermout), .datathermoutb(datathermoutb),
        .ready(ready), .compl_err(compl_err), .therm_err(therm_err),
        .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    assign obs = {databinout, databinoutb, datathermout, datathermoutb};

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit supply_in_window();
        return (v18 / 1.8 - 1.0 <= 0.05) && (1.0 - v18 / 1.8 <= 0.05) &&
               (v08 / 0.8 - 1.0 <= 0.05) && (1.0 - v08 / 0.8 <= 0.05) &&
               (vss <= 0.05) && (vss >= -0.05);
    endfunction

    function automatic bit shape_ok(input logic [NTHERM-1:0] t);
        logic [63:0] m;
        m = (64'd1 << $countones(t)) - 64'd1;
        return t == m[NTHERM-1:0];
    endfunction

    function automatic bit exp_driven();
        return m_mode != M_OFF;
    endfunction

    function automatic bit exp_ready();
        return m_mode == M_ACTIVE;
    endfunction

    function automatic word_t exp_out();
        word_t w;
        if (m_mode == M_ACTIVE) begin
            w = hist[LAT-1];
        end else begin
            w.b = '0; w.bb = '1; w.t = '0; w.tb = '1;
        end
        return w;
    endfunction

    function automatic bit exp_cerr();
        return (m_mode == M_ACTIVE) && ((hist[0].b !== ~hist[0].bb) || (hist[0].t !== ~hist[0].tb));
    endfunction

    function automatic bit exp_terr();
        return (m_mode == M_ACTIVE) && !shape_ok(hist[0].t);
    endfunction

    function automatic bit outputs_released();
        return ((databinout    === {NBIN{1'bz}})   || (databinout    === '0)) &&
               ((databinoutb   === {NBIN{1'bz}})   || (databinoutb   === '0)) &&
               ((datathermout  === {NTHERM{1'bz}}) || (datathermout  === '0)) &&
               ((datathermoutb === {NTHERM{1'bz}}) || (datathermoutb === '0));
    endfunction

    initial forever begin
        @(posedge clk or negedge rstb);
        if (!rstb) begin
            m_mode = M_OFF; wake_left = 0; m_sup = 1'b0; m_cnt = 0;
            hist.delete();
            for (int i = 0; i < LAT; i++) hist.push_back('0);
        end else begin
            sup_now = supply_in_window();
            if ((exp_cerr() || exp_terr()) && m_cnt < 255) m_cnt++;
            if (m_mode == M_OFF) begin
                if (pdb && m_sup) begin m_mode = M_WAKE; wake_left = WAKE_CYC; end
            end else if (!pdb) begin
                m_mode = M_OFF;
            end else if (!m_sup) begin
                m_mode = M_FAULT;
            end else if (m_mode == M_FAULT) begin
                m_mode = M_WAKE; wake_left = WAKE_CYC;
            end else if (m_mode == M_WAKE) begin
                wake_left--;
                if (wake_left == 0) m_mode = M_ACTIVE;
            end
            m_sup = sup_now;
            hist.push_front({datain, datainb, datatherm, datathermb});
            void'(hist.pop_back());
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_word(input bit good);
        logic [63:0] m;
        datain = NBIN'($urandom);
        m = (64'd1 << $urandom_range(0, NTHERM)) - 64'd1;
        datatherm  = m[NTHERM-1:0];
        datainb    = ~datain;
        datathermb = ~datatherm;
        if (!good) begin
            case ($urandom_range(0, 2))
                0: datainb = datain;
                1: datathermb = datatherm;
                default: begin
                    datatherm  = (NTHERM'($urandom) | (NTHERM'(1) << (NTHERM - 1))) & ~NTHERM'(1);
                    datathermb = ~datatherm;
                end
            endcase
        end
    endtask

    task automatic drive_supply(input bit good);
        bit hi;
        hi = ($urandom_range(0, 1) == 1);
        v18 = 1.8; v08 = 0.8; vss = 0.0;
        case ($urandom_range(0, 2))
            0: v18 = good ? (hi ? 1.88 : 1.72) : (hi ? 1.92 : 1.5);
            1: v08 = good ? (hi ? 0.83 : 0.77) : (hi ? 0.85 : 0.70);
            default: vss = good ? (hi ? 0.04 : -0.04) : (hi ? 0.06 : -0.07);
        endcase
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rstb = 1'b0;
        pdb = 1'b1; datain = 7'h55; datainb = 7'h55; datatherm = 17'h00005; datathermb = 17'h0;
        repeat (3) @(negedge clk);
        #2;
        n_vec++;
        if (ready !== 1'b0 || compl_err !== 1'b0 || therm_err !== 1'b0)
            begin n_err++; $display("FAIL reset_flags got=%b%b%b want=000", ready, compl_err, therm_err); end
        n_vec++;
        if (err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt got=%0d want=0", err_cnt); end
        n_vec++;
        if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
        n_vec++;
        if (!outputs_released()) begin n_err++; $display("FAIL reset_hiz got=%h want=z", obs); end
    endtask

    task automatic test_wake();
        int cyc, wake_seen;
        bit up;
        cyc = 0; wake_seen = 0; up = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        drive_word(1'b1);
        while (!up && cyc < 40) begin
            @(negedge clk);
            cyc++;
            n_vec++;
            if (ready !== exp_ready()) begin n_err++; $display("FAIL wake_ready cyc=%0d got=%b want=%b", cyc, ready, exp_ready()); end
            if (!ready && databinoutb === '1 && datathermoutb === '1 && databinout === '0 && datathermout === '0) wake_seen++;
            up = (ready === 1'b1);
            drive_word(1'b1);
        end
        n_vec++;
        if (cyc != WAKE_CYC + 2 || wake_seen != WAKE_CYC)
            begin n_err++; $display("FAIL wake_len got=%0d/%0d want=%0d/%0d", cyc, wake_seen, WAKE_CYC + 2, WAKE_CYC); end
    endtask

    task automatic test_datapath();
        datain = 7'h00; datainb = 7'h7F; datatherm = '0; datathermb = '1;
        repeat (LAT) @(negedge clk);
        datain = 7'h55; datainb = 7'h2A; datatherm = 17'h000FF; datathermb = ~17'h000FF;
        @(negedge clk);
        n_vec++;
        if (databinout !== 7'h00 || compl_err !== 1'b0 || therm_err !== 1'b0)
            begin n_err++; $display("FAIL lat_early got=%h/%b%b want=00/00", databinout, compl_err, therm_err); end
        datain = 7'h11; datainb = 7'h6E;
        @(negedge clk);
        n_vec++;
        if (databinout !== 7'h55 || databinoutb !== 7'h2A)
            begin n_err++; $display("FAIL lat_bin got=%h/%h want=55/2a", databinout, databinoutb); end
        n_vec++;
        if (datathermout !== 17'h000FF || datathermoutb !== 17'h1FF00)
            begin n_err++; $display("FAIL lat_therm got=%h/%h want=000ff/1ff00", datathermout, datathermoutb); end
        n_vec++;
        if (compl_err !== 1'b0 || therm_err !== 1'b0 || err_cnt !== 8'd0)
            begin n_err++; $display("FAIL lat_noerr got=%b%b/%0d want=00/0", compl_err, therm_err, err_cnt); end
    endtask

    task automatic test_errors();
        datain = 7'h12; datainb = 7'h6D; datatherm = 17'h00005; datathermb = ~17'h00005;
        @(negedge clk);
        n_vec++;
        if (therm_err !== 1'b1 || compl_err !== 1'b0 || err_cnt !== 8'd0)
            begin n_err++; $display("FAIL therm_pulse got=%b%b/%0d want=10/0", therm_err, compl_err, err_cnt); end
        datatherm = 17'h0000F; datathermb = ~17'h0000F;
        @(negedge clk);
        n_vec++;
        if (therm_err !== 1'b0 || err_cnt !== 8'd1)
            begin n_err++; $display("FAIL therm_clear got=%b/%0d want=0/1", therm_err, err_cnt); end
        datain = 7'h33; datainb = 7'h33;
        @(negedge clk);
        n_vec++;
        if (compl_err !== 1'b1 || therm_err !== 1'b0)
            begin n_err++; $display("FAIL compl_pulse got=%b%b want=10", compl_err, therm_err); end
        datatherm = 17'h00005; datathermb = ~17'h00005;
        @(negedge clk);
        n_vec++;
        if (compl_err !== 1'b1 || therm_err !== 1'b1 || err_cnt !== 8'd2)
            begin n_err++; $display("FAIL both_pulse got=%b%b/%0d want=11/2", compl_err, therm_err, err_cnt); end
        drive_word(1'b1);
        @(negedge clk);
        n_vec++;
        if (compl_err !== 1'b0 || therm_err !== 1'b0 || err_cnt !== 8'd3 || ready !== 1'b1)
            begin n_err++; $display("FAIL both_once got=%b%b/%0d/%b want=00/3/1", compl_err, therm_err, err_cnt, ready); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            drive_word(1'b0);
            @(negedge clk);
        end
        drive_word(1'b1);
        repeat (2) @(negedge clk);
        n_vec++;
        if (err_cnt !== 8'd255 || err_cnt !== 8'(m_cnt))
            begin n_err++; $display("FAIL err_sat got=%0d want=255", err_cnt); end
        n_vec++;
        if (ready !== 1'b1 || obs !== exp_out())
            begin n_err++; $display("FAIL err_noeffect got=%b/%h want=1/%h", ready, obs, exp_out()); end
    endtask

    task automatic test_supply_fault();
        int cyc, wake_seen;
        bit up;
        v08 = 0.70;
        @(negedge clk);
        n_vec++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL fault_edge1 got=%b want=1", ready); end
        @(negedge clk);
        n_vec++;
        if (ready !== 1'b0 || obs !== {7'h00, 7'h7F, 17'h00000, 17'h1FFFF})
            begin n_err++; $display("FAIL fault_safe got=%b/%h want=0/safe", ready, obs); end
        repeat (3) @(negedge clk);
        n_vec++;
        if (dbg_state !== 2'd3 || ready !== 1'b0)
            begin n_err++; $display("FAIL fault_hold got=%0d/%b want=3/0", dbg_state, ready); end
        v08 = 0.80;
        cyc = 0; wake_seen = 0; up = 1'b0;
        while (!up && cyc < 40) begin
            @(negedge clk);
            cyc++;
            n_vec++;
            if (ready !== exp_ready() || obs !== exp_out())
                begin n_err++; $display("FAIL recover cyc=%0d got=%b/%h want=%b/%h", cyc, ready, obs, exp_ready(), exp_out()); end
            if (dbg_state === 2'd1) wake_seen++;
            up = (ready === 1'b1);
        end
        n_vec++;
        if (cyc != WAKE_CYC + 2 || wake_seen != WAKE_CYC)
            begin n_err++; $display("FAIL recover_len got=%0d/%0d want=%0d/%0d", cyc, wake_seen, WAKE_CYC + 2, WAKE_CYC); end
    endtask

    task automatic test_pdb_priority();
        int cyc;
        datain = 7'h55; datainb = 7'h2A; datatherm = 17'h1FFFF; datathermb = 17'h0;
        pdb = 1'b0; v18 = 1.5;
        @(negedge clk);
        n_vec++;
        if (dbg_state !== 2'd0 || ready !== 1'b0)
            begin n_err++; $display("FAIL pdb_off got=%0d/%b want=0/0", dbg_state, ready); end
        repeat (2) @(negedge clk);
        n_vec++;
        if (!outputs_released() || dbg_state !== 2'd0)
            begin n_err++; $display("FAIL pdb_hiz got=%h/%0d want=z/0", obs, dbg_state); end
        pdb = 1'b1; v18 = 1.8;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc != WAKE_CYC + 2) begin n_err++; $display("FAIL pdb_rewake got=%0d want=%0d", cyc, WAKE_CYC + 2); end
    endtask

    task automatic test_reset_mid_wake();
        int cyc;
        pdb = 1'b0;
        @(negedge clk);
        pdb = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if (dbg_state !== 2'd1) begin n_err++; $display("FAIL midwake_pre got=%0d want=1", dbg_state); end
        #2 rstb = 1'b0;
        #1;
        n_vec++;
        if (dbg_state !== 2'd0 || ready !== 1'b0 || err_cnt !== 8'd0 || compl_err !== 1'b0 || therm_err !== 1'b0)
            begin n_err++; $display("FAIL midwake_rst got=%0d/%b/%0d/%b%b want=0/0/0/00", dbg_state, ready, err_cnt, compl_err, therm_err); end
        n_vec++;
        if (!outputs_released()) begin n_err++; $display("FAIL midwake_hiz got=%h want=z", obs); end
        @(negedge clk);
        rstb = 1'b1;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            n_vec++;
            if (ready !== exp_ready()) begin n_err++; $display("FAIL midwake_seq cyc=%0d got=%b want=%b", cyc, ready, exp_ready()); end
        end
        n_vec++;
        if (cyc != WAKE_CYC + 2) begin n_err++; $display("FAIL midwake_len got=%0d want=%0d", cyc, WAKE_CYC + 2); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_vec++;
            if (exp_driven() ? (obs !== exp_out()) : !outputs_released())
                begin n_err++; $display("FAIL rand_data cyc=%0d got=%h want=%h drv=%b", c, obs, exp_out(), exp_driven()); end
            n_vec++;
            if ({ready, compl_err, therm_err} !== {exp_ready(), exp_cerr(), exp_terr()})
                begin n_err++; $display("FAIL rand_flags cyc=%0d got=%b%b%b want=%b%b%b", c, ready, compl_err, therm_err, exp_ready(), exp_cerr(), exp_terr()); end
            n_vec++;
            if (err_cnt !== 8'(m_cnt))
                begin n_err++; $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", c, err_cnt, m_cnt); end
            pdb = ($urandom_range(0, 59) != 0);
            drive_supply($urandom_range(0, 59) != 0);
            drive_word($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        rstb = 1'b1; pdb = 1'b0;
        v18 = 1.8; v08 = 0.8; vss = 0.0;
        datain = '0; datainb = '0; datatherm = '0; datathermb = '0;
        test_reset();
        test_wake();
        test_datapath();
        test_errors();
        test_saturate();
        test_supply_fault();
        test_pdb_priority();
        test_reset_mid_wake();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d vectors", n_vec);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dac_driver_resync.md
DAC_DRIVER_RESYNC -- requirements
Module: dac_driver_resync

Interface
REQ-001 Parameter NBIN, default 7: binary segment width, legal 1..16.
REQ-002 Parameter NTHERM, default 17: thermometer segment width, legal 1..64.
REQ-003 Parameter LAT, default 2: retiming pipeline depth in clk cycles, legal 1..4.
REQ-004 Parameter WAKE_CYC, default 8: wake-up settle cycles, legal LAT..255.
REQ-005 Parameters VDD18_REF 1.8, VDD08_REF 0.8 (real, V): supply nominals, tolerance +/-5%; vssana window +/-0.05 V.
REQ-006 clk  input  1  sampling clock, rising edge active.
REQ-007 rstb  input  1  reset, asynchronous, active-low.
REQ-008 pdb  input  1  power-down negate; 1 = enabled.
REQ-009 vddana_1p8, vddana_0p8, vssana  input  real  supply levels.
REQ-010 datain, datainb  input  NBIN  binary control and its complement.
REQ-011 datatherm, datathermb  input  NTHERM  thermometer control and its complement.
REQ-012 databinout, databinoutb  output  NBIN  retimed binary switch drive.
REQ-013 datathermout, datathermoutb  output  NTHERM  retimed thermometer switch drive.
REQ-014 ready  output  1  high only in ACTIVE.
REQ-015 compl_err, therm_err  output  1  one-cycle error pulses.
REQ-016 err_cnt  output  8  saturating count of error events.

Function
REQ-017 supply_ok SHALL be computed from the three supply windows (inclusive bounds) and registered on clk; FSM uses only the registered value.
REQ-018 All four data inputs SHALL pass through an LAT-stage register pipeline clocked every cycle regardless of state; stage 1 captures inputs directly.
REQ-019 FSM states: OFF, WAKE, ACTIVE, FAULT.
REQ-020 OFF: all data outputs 'z; exits to WAKE when pdb=1 and supply_ok=1.
REQ-021 WAKE: outputs drive safe code (true = all 0, complement = all 1); wake counter loads 0 on entry, increments per cycle; enter ACTIVE on the edge where counter reaches WAKE_CYC-1.
REQ-022 ACTIVE: outputs equal final pipeline stage; input sampled at edge k appears on outputs after edge k+LAT-1 (LAT cycles latency); ready=1.
REQ-023 Any state except OFF: pdb=0 -> OFF on next edge; else supply_ok=0 -> FAULT on next edge; pdb=0 has priority over supply fault.
REQ-024 FAULT: outputs safe code, ready=0; when supply_ok=1 and pdb=1 -> WAKE with counter restarted from 0.
REQ-025 compl_err SHALL pulse for one cycle when, in ACTIVE, stage-1 binary or thermometer word is not the exact bitwise complement of its negate word.
REQ-026 therm_err SHALL pulse for one cycle when, in ACTIVE, stage-1 datatherm is not of form 0..01..1 (contiguous ones from LSB; all-0 and all-1 legal).
REQ-027 err_cnt SHALL increment by 1 per cycle in which compl_err or therm_err is high (both high counts once), saturating at 255; cleared only by reset.
REQ-028 Errors SHALL NOT alter data outputs or FSM state.

Reset
REQ-029 rstb=0 SHALL immediately, independent of clk, force state OFF, all pipeline stages 0, wake counter 0, supply_ok register 0, ready 0, compl_err 0, therm_err 0, err_cnt 0, data outputs 'z.
REQ-030 Reset asserted mid-WAKE or mid-ACTIVE SHALL abort without completing the wake count; after release, first possible transition is OFF->WAKE on an edge where registered supply_ok=1 and pdb=1.

Verification (NBIN=7, NTHERM=17, LAT=2, WAKE_CYC=8)
REQ-031 Nominal supplies, pdb=1 after reset -> OFF then WAKE, safe code for 8 cycles, ready=1 on 9th edge after entering WAKE.
REQ-032 ACTIVE, datain 7'h55/datainb 7'h2A applied at edge k -> databinout=7'h55, databinoutb=7'h2A visible after edge k+1; no error pulse.
REQ-033 ACTIVE, vddana_0p8 stepped to 0.70 V -> FAULT within 2 edges, safe code, ready=0; restored to 0.80 V -> WAKE, ready after 8 further cycles.
REQ-034 ACTIVE, datatherm 17'h00005 with correct complement -> therm_err pulse 1 cycle, err_cnt 0->1; datainb=datain -> compl_err pulse; 300 bad words -> err_cnt=255.
REQ-035 pdb=0 and vddana_1p8=1.5 V on the same edge in ACTIVE -> OFF, outputs 'z; rstb pulse mid-WAKE -> all outputs at reset values immediately.
